alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-cycle controller that issues operations to the 4-bit combinational ALU and closes the loop through the register file. It accepts one instruction at a time over a valid/ready handshake, reads two source registers, presents operands and opcode to the ALU, captures the ALU result, and writes it back to the destination register. It sits between the instruction source (testbench or future fetch unit) and the register-file/ALU datapath.

## Interface
- DATA_W, 4, operand/result width
- ADDR_W, 2, register address width (2**ADDR_W registers)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept
- instr_op  in  4  opcode (see Operation)
- instr_rd / instr_ra / instr_rb  in  ADDR_W each  destination / source A / source B
- rf_ra_addr / rf_rb_addr  out  ADDR_W each  register-file read addresses
- rf_ra_data / rf_rb_data  in  DATA_W each  combinational read data
- alu_a / alu_b  out  DATA_W each  ALU operands
- alu_op  out  4  ALU operation code
- alu_y  in  DATA_W  ALU result (combinational)
- rf_we  out  1  register-file write enable
- rf_wa  out  ADDR_W  write address
- rf_wd  out  DATA_W  write data
- done  out  1  one-cycle completion pulse
- result  out  DATA_W  last captured result
- zero  out  1  result == 0

## Operation
- Opcodes: 0 PASS_A, 1 INC_A, 2 ADD, 3 ADD_INC (a+b+1), 4 ADD_NOTB (a+~b), 5 SUB (a+~b+1), 6 DEC_A, 7 PASS_B, 8 AND, 9 OR, 10 XOR, 11 NOT_A, 12 SHL1, 13 SHR1, 14 CLR, 15 NOP.
- All arithmetic modulo 2**DATA_W; carry-out discarded.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch op/rd/ra/rb → READ.
  - READ: rf_ra_addr/rf_rb_addr driven from latched ra/rb; capture rf_ra_data/rf_rb_data into operand registers at end of cycle. If op==NOP → WB, else → EXEC.
  - EXEC: alu_a/alu_b from operand registers, alu_op = latched op; capture alu_y into result and update zero at end of cycle → WB.
  - WB: rf_we=1 (0 if NOP), rf_wa=latched rd, rf_wd=result; done=1 → IDLE.
- NOP: no register write, result/zero unchanged, done still pulses.
- rd may equal ra or rb; operands are already captured, so overwrite is safe.
- Outputs outside their active state: rf_we=0, done=0; address/operand outputs hold latched values.

## Timing
- Reset values: state IDLE, instr_ready=1, rf_we=0, done=0, result=0, zero=1, all address/operand/op registers 0, alu_op=0.
- Accept at edge T0 → READ cycle T0..T1, EXEC T1..T2, WB T2..T3 (rf_we and done high), IDLE after T3.
- Latency accept→done = 3 cycles; throughput one instruction per 4 cycles.
- instr_ready low in READ/EXEC/WB; instr_valid ignored there (no buffering). Back-to-back: next accept earliest at the edge ending the first IDLE cycle after WB.
- Write in WB lands before the next instruction's READ, so read-after-write needs no forwarding.
- Reset asserted mid-instruction: immediate return to IDLE, no write issued, done not pulsed, result cleared.

## Structure
- Shared package: DATA_W/ADDR_W defaults, opcode constants (OP_PASS_A … OP_NOP), state enum encoding.
- One sub-module natural: alu_op_sequencer_fsm (state register, next-state logic, rf_we/done/instr_ready decode); datapath registers in the top.

## Test plan
- Reset: rst_n low → instr_ready=1, rf_we=0, done=0, result=0, zero=1.
- R1=3, R2=5; ADD rd=0 ra=1 rb=2 → done exactly 3 cycles after accept, rf_we with rf_wa=0, rf_wd=8, zero=0.
- R1=3, R2=3; SUB rd=3 ra=1 rb=2 → rf_wd=0, zero=1; then INC_A rd=3 ra=3 → rf_wd=1 (RAW through register file).
- R1=4'hF; INC_A rd=1 ra=1 → rf_wd=0 (wrap); SHL1 of 4'h9 → 4'h2; SHR1 of 4'h9 → 4'h4.
- NOP with instr_valid held high → done pulses, rf_we never 1, result unchanged; instr_valid held during busy accepted only once per 4 cycles.
- Assert rst_n low during EXEC of ADD → no rf_we pulse, no done, back to IDLE with result=0.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// ============================================================================
// alu_op_sequencer_pkg : shared widths, ALU opcodes and sequencer state codes
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package alu_op_sequencer_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 2;

  localparam logic [3:0] OP_PASS_A  = 4'd0;
  localparam logic [3:0] OP_INC_A   = 4'd1;
  localparam logic [3:0] OP_ADD     = 4'd2;
  localparam logic [3:0] OP_ADD_INC = 4'd3;
  localparam logic [3:0] OP_ADD_NOTB= 4'd4;
  localparam logic [3:0] OP_SUB     = 4'd5;
  localparam logic [3:0] OP_DEC_A   = 4'd6;
  localparam logic [3:0] OP_PASS_B  = 4'd7;
  localparam logic [3:0] OP_AND     = 4'd8;
  localparam logic [3:0] OP_OR      = 4'd9;
  localparam logic [3:0] OP_XOR     = 4'd10;
  localparam logic [3:0] OP_NOT_A   = 4'd11;
  localparam logic [3:0] OP_SHL1    = 4'd12;
  localparam logic [3:0] OP_SHR1    = 4'd13;
  localparam logic [3:0] OP_CLR     = 4'd14;
  localparam logic [3:0] OP_NOP     = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_op_sequencer_fsm.sv
// ============================================================================
// alu_op_sequencer_fsm : IDLE/READ/EXEC/WB control with handshake and strobes
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_op_sequencer_fsm
  import alu_op_sequencer_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   instr_valid_i,
  input  logic   is_nop_i,
  output state_e state_o,
  output logic   instr_ready_o,
  output logic   accept_o,
  output logic   rf_we_o,
  output logic   done_o
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    instr_ready_o = 1'b0;
    accept_o      = 1'b0;
    rf_we_o       = 1'b0;
    done_o        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          accept_o = 1'b1;
          state_d  = ST_READ;
        end
      end
      // NOP has nothing to compute, so it skips straight to the completion cycle
      ST_READ: state_d = is_nop_i ? ST_WB : ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        rf_we_o = !is_nop_i;
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_o = state_q;

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// alu_op_sequencer : issues one instruction at a time to an external ALU and
//                    writes the result back to the register file
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_ra,
  input  logic [ADDR_W-1:0] instr_rb,
  output logic [ADDR_W-1:0] rf_ra_addr,
  output logic [ADDR_W-1:0] rf_rb_addr,
  input  logic [DATA_W-1:0] rf_ra_data,
  input  logic [DATA_W-1:0] rf_rb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_y,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  state_e            state;
  logic              accept;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic              zero_q, zero_d;

  alu_op_sequencer_fsm u_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid_i (instr_valid),
    .is_nop_i      (op_q == OP_NOP),
    .state_o       (state),
    .instr_ready_o (instr_ready),
    .accept_o      (accept),
    .rf_we_o       (rf_we),
    .done_o        (done)
  );

  always_comb begin
    op_d     = op_q;
    rd_d     = rd_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;
    if (accept) begin
      op_d = instr_op;
      rd_d = instr_rd;
      ra_d = instr_ra;
      rb_d = instr_rb;
    end
    if (state == ST_READ) begin
      a_d = rf_ra_data;
      b_d = rf_rb_data;
    end
    if (state == ST_EXEC) begin
      result_d = alu_y;
      zero_d   = (alu_y == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      op_q     <= op_d;
      rd_q     <= rd_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign rf_ra_addr = ra_q;
  assign rf_rb_addr = rb_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rf_wa      = rd_q;
  assign rf_wd      = result_q;
  assign result     = result_q;
  assign zero       = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// tb_alu_op_sequencer : directed bench with bench-side register file and ALU
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] instr_op = 4'd0;
  logic [1:0] instr_rd = 2'd0, instr_ra = 2'd0, instr_rb = 2'd0;
  logic [1:0] rf_ra_addr, rf_rb_addr, rf_wa;
  logic [3:0] rf_ra_data, rf_rb_data, alu_a, alu_b, alu_op, alu_y, rf_wd, result;
  logic       rf_we, done, zero;

  logic [3:0] rf [4];
  logic       pl_en = 1'b0;
  logic [1:0] pl_addr = 2'd0;
  logic [3:0] pl_data = 4'd0;

  int n_checks = 0;
  int n_errors = 0;

  alu_op_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_ra    (instr_ra),
    .instr_rb    (instr_rb),
    .rf_ra_addr  (rf_ra_addr),
    .rf_rb_addr  (rf_rb_addr),
    .rf_ra_data  (rf_ra_data),
    .rf_rb_data  (rf_rb_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_y       (alu_y),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .done        (done),
    .result      (result),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  // Environment: register file with a bench preload port, and the combinational ALU
  always @(posedge clk) begin
    if (rf_we)      rf[rf_wa]   <= rf_wd;
    else if (pl_en) rf[pl_addr] <= pl_data;
  end
  assign rf_ra_data = rf[rf_ra_addr];
  assign rf_rb_data = rf[rf_rb_addr];

  always_comb begin
    alu_y = 4'd0;
    case (alu_op)
      4'd0:  alu_y = alu_a;
      4'd1:  alu_y = alu_a + 4'd1;
      4'd2:  alu_y = alu_a + alu_b;
      4'd3:  alu_y = alu_a + alu_b + 4'd1;
      4'd4:  alu_y = alu_a + ~alu_b;
      4'd5:  alu_y = alu_a + ~alu_b + 4'd1;
      4'd6:  alu_y = alu_a - 4'd1;
      4'd7:  alu_y = alu_b;
      4'd8:  alu_y = alu_a & alu_b;
      4'd9:  alu_y = alu_a | alu_b;
      4'd10: alu_y = alu_a ^ alu_b;
      4'd11: alu_y = ~alu_a;
      4'd12: alu_y = alu_a << 1;
      4'd13: alu_y = alu_a >> 1;
      default: alu_y = 4'd0;
    endcase
  end

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic preload(input logic [1:0] addr, input logic [3:0] data);
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Called at #1 after an edge with the sequencer idle; returns at #1 after the edge back to IDLE
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [1:0] rd,
                           input logic [1:0] ra, input logic [1:0] rb,
                           input logic [3:0] exp_wd, input logic exp_zero);
    check({tag, "_ready"}, instr_ready, 1);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check({tag, "_read_busy"}, instr_ready, 0);
    check({tag, "_read_done"}, done, 0);
    check({tag, "_read_addr"}, {rf_ra_addr, rf_rb_addr}, {ra, rb});
    @(posedge clk); #1;
    check({tag, "_exec_done"}, done, 0);
    check({tag, "_exec_we"}, rf_we, 0);
    check({tag, "_exec_op"}, alu_op, op);
    @(posedge clk); #1;
    check({tag, "_wb_done"}, done, 1);
    check({tag, "_wb_we"}, rf_we, 1);
    check({tag, "_wb_wa"}, rf_wa, rd);
    check({tag, "_wb_wd"}, rf_wd, exp_wd);
    check({tag, "_wb_zero"}, zero, exp_zero);
    @(posedge clk); #1;
    check({tag, "_idle_done"}, done, 0);
    check({tag, "_idle_ready"}, instr_ready, 1);
    check({tag, "_rf_written"}, rf[rd], exp_wd);
  endtask

  initial begin
    int n_done, n_we, n_rdy;
    logic [3:0] saved;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_we", rf_we, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_alu_op", alu_op, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    preload(2'd1, 4'd3);
    preload(2'd2, 4'd5);
    run_instr("add", 4'd2, 2'd0, 2'd1, 2'd2, 4'd8, 1'b0);

    preload(2'd2, 4'd3);
    run_instr("sub", 4'd5, 2'd3, 2'd1, 2'd2, 4'd0, 1'b1);
    run_instr("inc_raw", 4'd1, 2'd3, 2'd3, 2'd0, 4'd1, 1'b0);

    preload(2'd1, 4'hF);
    run_instr("inc_wrap", 4'd1, 2'd1, 2'd1, 2'd0, 4'd0, 1'b1);
    preload(2'd2, 4'h9);
    run_instr("shl1", 4'd12, 2'd0, 2'd2, 2'd0, 4'h2, 1'b0);
    run_instr("shr1", 4'd13, 2'd0, 2'd2, 2'd0, 4'h4, 1'b0);
    preload(2'd1, 4'hC);
    run_instr("xor", 4'd10, 2'd3, 2'd1, 2'd2, 4'h5, 1'b0);
    run_instr("add_notb", 4'd4, 2'd3, 2'd1, 2'd2, 4'h2, 1'b0);

    // NOP held valid: accept, READ, WB, IDLE, accept again -> two done pulses in six edges
    saved = result;
    instr_valid = 1'b1; instr_op = 4'd15; instr_rd = 2'd2; instr_ra = 2'd1; instr_rb = 2'd1;
    n_done = 0; n_we = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done)  n_done++;
      if (rf_we) n_we++;
    end
    instr_valid = 1'b0;
    check("nop_done_count", n_done, 2);
    check("nop_we_count", n_we, 0);
    check("nop_result_held", result, saved);
    check("nop_rf_untouched", rf[2], 4'h9);

    // ADD held valid: one accept per four edges
    preload(2'd1, 4'd3);
    preload(2'd2, 4'd5);
    instr_valid = 1'b1; instr_op = 4'd2; instr_rd = 2'd0; instr_ra = 2'd1; instr_rb = 2'd2;
    n_done = 0; n_rdy = 0; n_we = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done)        n_done++;
      if (rf_we)       n_we++;
      if (instr_ready) n_rdy++;
    end
    instr_valid = 1'b0;
    check("thru_done_count", n_done, 2);
    check("thru_we_count", n_we, 2);
    check("thru_ready_count", n_rdy, 2);
    check("thru_result", result, 4'd8);

    // Reset during EXEC of ADD
    preload(2'd0, 4'hA);
    instr_valid = 1'b1; instr_op = 4'd2; instr_rd = 2'd0; instr_ra = 2'd1; instr_rb = 2'd2;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("rstx_in_exec", alu_op, 4'd2);
    rst_n = 1'b0;
    #1;
    check("rstx_ready", instr_ready, 1);
    check("rstx_result", result, 0);
    check("rstx_zero", zero, 1);
    n_done = 0; n_we = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) rst_n = 1'b1;
      @(posedge clk); #1;
      if (done)  n_done++;
      if (rf_we) n_we++;
    end
    check("rstx_no_done", n_done, 0);
    check("rstx_no_we", n_we, 0);
    check("rstx_rf_kept", rf[0], 4'hA);
    check("rstx_idle", instr_ready, 1);

    run_instr("post_rst_add", 4'd2, 2'd0, 2'd1, 2'd2, 4'd8, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
